// File: rtl/csa_resolve_if.sv
// Operand/result handshake bundle for csa_resolve.
// The master drives operands and output-side ready; the slave is the resolver.
interface csa_resolve_if #(
  parameter int unsigned MAX = 7
);
  logic [MAX-1:0] pv_s;
  logic [MAX-1:0] pv_c;
  logic           in_valid;
  logic           in_ready;
  logic [MAX:0]   out_sum;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  modport master (
    output pv_s, pv_c, in_valid, out_ready,
    input  in_ready, out_sum, out_valid, busy
  );

  modport slave (
    input  pv_s, pv_c, in_valid, out_ready,
    output in_ready, out_sum, out_valid, busy
  );
endinterface

// File: rtl/csa_resolve.sv
// Resolves a carry-save pair into one binary value, SEG bits per cycle,
// with a registered carry between segments.
module csa_resolve #(
  parameter int unsigned MAX = 7,
  parameter int unsigned SEG = 4
) (
  input logic          clk,
  input logic          rst,
  csa_resolve_if.slave bus_io
);
  localparam int unsigned NSEG = (MAX + SEG - 1) / SEG;
  localparam int unsigned PW   = NSEG * SEG;
  localparam int unsigned CntW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                      state_q;
  logic [CntW-1:0]             cnt_q;
  logic                        carry_q;
  logic [NSEG-1:0][SEG-1:0]    a_q;
  logic [NSEG-1:0][SEG-1:0]    b_q;
  logic [NSEG-1:0][SEG-1:0]    res_q;
  logic [MAX:0]                out_sum_q;
  logic                        out_valid_q;

  logic [SEG:0]                seg_sum;
  logic [NSEG-1:0][SEG-1:0]    res_d;
  logic [PW-1:0]               res_flat;
  logic [PW:0]                 res_ext;
  logic                        last_seg;

  always_comb begin
    seg_sum  = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]} + {{SEG{1'b0}}, carry_q};
    res_d    = res_q;
    res_d[cnt_q] = seg_sum[SEG-1:0];
    res_flat = res_d;
    // When SEG divides MAX there is no padding, so bit MAX is the final carry-out.
    res_ext  = {seg_sum[SEG], res_flat};
    last_seg = (cnt_q == CntW'(NSEG - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.in_valid) begin
            a_q     <= PW'(bus_io.pv_s);
            b_q     <= PW'(bus_io.pv_c);
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          res_q   <= res_d;
          carry_q <= seg_sum[SEG];
          if (last_seg) begin
            out_sum_q   <= (MAX + 1)'(res_ext);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_sum   = out_sum_q;
endmodule

// File: tb/tb_csa_resolve.sv
// Directed and random-stream checks of csa_resolve for three MAX/SEG shapes,
// using a scoreboard of expected sums and accept cycles.
module tb_csa_resolve;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_resolve_if #(.MAX(7)) if_a ();
  csa_resolve_if #(.MAX(7)) if_b ();
  csa_resolve_if #(.MAX(9)) if_c ();

  csa_resolve #(.MAX(7), .SEG(4)) u_a (.clk(clk), .rst(rst), .bus_io(if_a));
  csa_resolve #(.MAX(7), .SEG(7)) u_b (.clk(clk), .rst(rst), .bus_io(if_b));
  csa_resolve #(.MAX(9), .SEG(2)) u_c (.clk(clk), .rst(rst), .bus_io(if_c));

  int         sel = 0;
  int         nseg = 2;
  logic [8:0] drv_s = '0;
  logic [8:0] drv_c = '0;
  logic       drv_v = 1'b0;
  logic       dir_rdy = 1'b0;
  logic       rnd_rdy = 1'b0;
  logic       rnd_bit = 1'b0;
  logic       rdy_m;

  logic       in_ready_m;
  logic       out_valid_m;
  logic       busy_m;
  logic [9:0] out_sum_m;

  assign rdy_m = rnd_rdy ? rnd_bit : dir_rdy;

  assign if_a.pv_s = drv_s[6:0];
  assign if_a.pv_c = drv_c[6:0];
  assign if_a.in_valid = drv_v && (sel == 0);
  assign if_a.out_ready = rdy_m;
  assign if_b.pv_s = drv_s[6:0];
  assign if_b.pv_c = drv_c[6:0];
  assign if_b.in_valid = drv_v && (sel == 1);
  assign if_b.out_ready = rdy_m;
  assign if_c.pv_s = drv_s;
  assign if_c.pv_c = drv_c;
  assign if_c.in_valid = drv_v && (sel == 2);
  assign if_c.out_ready = rdy_m;

  always_comb begin
    case (sel)
      0: begin
        in_ready_m = if_a.in_ready; out_valid_m = if_a.out_valid;
        busy_m = if_a.busy; out_sum_m = 10'(if_a.out_sum);
      end
      1: begin
        in_ready_m = if_b.in_ready; out_valid_m = if_b.out_valid;
        busy_m = if_b.busy; out_sum_m = 10'(if_b.out_sum);
      end
      default: begin
        in_ready_m = if_c.in_ready; out_valid_m = if_c.out_valid;
        busy_m = if_c.busy; out_sum_m = if_c.out_sum;
      end
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_out = 0;

  typedef struct packed {
    logic [9:0]  exp;
    logic [31:0] acc;
  } sb_t;
  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // Scoreboard: push on observed accept, check latency/sum on output rise and handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin : mon
    sb_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (drv_v && (sel >= 0) && in_ready_m) begin
        e.exp = 10'(drv_s) + 10'(drv_c);
        e.acc = 32'(cyc + 1);
        sb_q.push_back(e);
      end
      if (out_valid_m && !prev_ov) begin
        chk("out_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          chk("latency", 32'(cyc) - sb_q[0].acc, 32'(nseg));
          chk("sum_rise", 32'(out_sum_m), 32'(sb_q[0].exp));
        end
      end
      if (out_valid_m && rdy_m) begin
        chk("hs_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          chk("sum_hs", 32'(out_sum_m), 32'(sb_q[0].exp));
          void'(sb_q.pop_front());
        end
        n_out++;
      end
      prev_ov = out_valid_m;
    end
  end

  task automatic send(input logic [8:0] s, input logic [8:0] c);
    int t = 0;
    drv_s = s;
    drv_c = c;
    drv_v = 1'b1;
    while (!in_ready_m && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_timeout", 32'(t < 200), 32'd1);
    @(posedge clk); #1;
    drv_v = 1'b0;
  endtask

  task automatic wait_ov();
    int t = 0;
    while (!out_valid_m && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ov_timeout", 32'(out_valid_m), 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] mask;
    int         base;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready_m), 32'd1);

    // Async reset from DONE, mid-cycle, with no clock edge in between.
    dir_rdy = 1'b0;
    send(9'h7F, 9'h7F);
    wait_ov();
    chk("pre_rst_sum", 32'(out_sum_m), 32'hFE);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready_m), 32'd1);
    chk("arst_out_valid", 32'(out_valid_m), 32'd0);
    chk("arst_out_sum", 32'(out_sum_m), 32'h00);
    chk("arst_busy", 32'(busy_m), 32'd0);
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    dir_rdy = 1'b1;
    send(9'h7F, 9'h7F);
    drain();
    chk("sum_7f7f", 32'(out_sum_m), 32'hFE);
    send(9'h0F, 9'h01);
    drain();
    send(9'h40, 9'h40);
    drain();
    chk("sum_4040", 32'(out_sum_m), 32'h80);

    // Backpressure: DONE held, new data offered but refused.
    dir_rdy = 1'b0;
    send(9'h12, 9'h34);
    wait_ov();
    drv_s = 9'h21;
    drv_c = 9'h0F;
    drv_v = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid_m), 32'd1);
      chk("bp_out_sum", 32'(out_sum_m), 32'h46);
      chk("bp_in_ready", 32'(in_ready_m), 32'd0);
    end
    dir_rdy = 1'b1;
    @(posedge clk); #1;
    dir_rdy = 1'b0;
    chk("bp_idle", 32'(in_ready_m), 32'd1);
    chk("bp_sum_kept", 32'(out_sum_m), 32'h46);
    @(posedge clk); #1;
    drv_v = 1'b0;
    chk("bp_accepted", 32'(busy_m), 32'd1);
    dir_rdy = 1'b1;
    drain();
    chk("sum_210f", 32'(out_sum_m), 32'h30);

    // Reset during CALC discards the pending result.
    send(9'h55, 9'h2A);
    chk("calc_busy", 32'(busy_m), 32'd1);
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    chk("calc_rst_valid", 32'(out_valid_m), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_stale_out", 32'(out_valid_m), 32'd0);
    end
    send(9'h03, 9'h05);
    drain();
    chk("sum_0305", 32'(out_sum_m), 32'h08);

    // Random back-to-back streams with random out_ready.
    for (int cfg = 0; cfg < 3; cfg++) begin
      sel  = cfg;
      nseg = (cfg == 0) ? 2 : (cfg == 1) ? 1 : 5;
      mask = (cfg == 2) ? 9'h1FF : 9'h07F;
      base = n_out;
      rnd_rdy = 1'b1;
      for (int n = 0; n < 50; n++) begin
        send(9'($urandom) & mask, 9'($urandom) & mask);
      end
      drain();
      rnd_rdy = 1'b0;
      dir_rdy = 1'b1;
      @(posedge clk); #1;
      chk("stream_count", 32'(n_out - base), 32'd50);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
